// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Galois LFSR / serial CRC engine.
//   Steps a WIDTH-bit Galois register with tap mask POLY. In LFSR mode the
//   engine recovers from the all-zero lock-up state and measures the cycle
//   length relative to the last loaded/reset value. In CRC mode the serial
//   input is folded into the feedback and zero is a legal state.
// Ports:
//   clk        in   rising-edge clock
//   rst_b      in   asynchronous reset, active low
//   en         in   advance one step this cycle
//   load       in   load seed_i this cycle (overrides en)
//   seed_i     in   runtime seed [WIDTH-1:0]
//   crc_mode   in   1: XOR din into feedback; 0: free-running LFSR
//   din        in   serial data bit (CRC mode only)
//   q          out  current state
//   sout       out  q[WIDTH-1]
//   wrap       out  1-cycle pulse: last step returned to the reference value
//   period     out  steps in the last completed cycle
//   period_vld out  period holds a valid measurement
//   lockup     out  1-cycle pulse: all-zero state was replaced by SEED
module lfsr_gen #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = 8'h1D,
   parameter logic [WIDTH-1:0] SEED  = 8'hFF
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             crc_mode,
   input  logic             din,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             period_vld,
   output logic             lockup
);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;      // value whose recurrence ends a period
   logic [WIDTH-1:0] cnt_q, cnt_d;      // steps taken since the reference value
   logic [WIDTH-1:0] period_q, period_d;
   logic             period_vld_q, period_vld_d;
   logic             wrap_q, wrap_d;
   logic             lockup_q, lockup_d;

   logic             fb;
   logic [WIDTH-1:0] nq;
   logic [WIDTH-1:0] cnt_inc;

   // Galois step: stage 0 takes the feedback, tapped stages XOR it in.
   always_comb begin
      fb    = state_q[WIDTH-1] ^ (crc_mode & din);
      nq    = '0;
      nq[0] = fb;
      for (int i = 1; i < int'(WIDTH); i++) begin
         nq[i] = state_q[i-1] ^ (POLY[i] & fb);
      end
   end

   // Saturating increment so a stuck or non-returning sequence never
   // reports a short, wrapped-around period.
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

   always_comb begin
      state_d      = state_q;
      ref_d        = ref_q;
      cnt_d        = cnt_q;
      period_d     = period_q;
      period_vld_d = period_vld_q;
      wrap_d       = 1'b0;
      lockup_d     = 1'b0;
      if (load) begin
         state_d      = seed_i;
         ref_d        = seed_i;
         cnt_d        = '0;
         period_vld_d = 1'b0;
      end else if (!crc_mode && (state_q == '0)) begin
         // Zero is a fixed point of the free LFSR; restart from SEED.
         state_d  = SEED;
         ref_d    = SEED;
         cnt_d    = '0;
         lockup_d = 1'b1;
      end else if (en) begin
         state_d = nq;
         if (!crc_mode) begin
            if (nq == ref_q) begin
               wrap_d       = 1'b1;
               period_d     = cnt_inc;
               period_vld_d = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q      <= SEED;
         ref_q        <= SEED;
         cnt_q        <= '0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         wrap_q       <= 1'b0;
         lockup_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ref_q        <= ref_d;
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         wrap_q       <= wrap_d;
         lockup_q     <= lockup_d;
      end
   end

   assign q          = state_q;
   assign sout       = state_q[WIDTH-1];
   assign wrap       = wrap_q;
   assign period     = period_q;
   assign period_vld = period_vld_q;
   assign lockup     = lockup_q;

endmodule
